sterownik_rejestru: RTL and testbench

- Command sequencer for the 4-bit bidirectional shift register (S1 S0: 00 hold, 01 shift right, 10 shift left, 11 parallel load).
- Accepts one command at a time over a valid/ready handshake: load, shift right N, shift left N, or clear.
- Drives the register's S1/S0/I/clear inputs cycle by cycle, then captures Q and reports completion with a one-cycle DONE pulse.
- Sits between the host logic and the shift register instance, on the same clock.

---
 rtl/sterownik_rejestru_pkg.sv | 32 +++
 rtl/sterownik_rejestru_if.sv | 27 ++
 rtl/rejestr_przesuwajacy.sv | 27 ++
 rtl/sterownik_rejestru.sv | 126 ++++++++++++
 tb/tb_sterownik_rejestru.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sterownik_rejestru_pkg.sv
// Shared types and encodings for the shift-register command sequencer.
package sterownik_pkg;

  // Host command opcodes
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  // Sequencer FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CLEAR = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // S1/S0 mode encodings of the shift register
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Shift direction mode for a shift opcode
  function automatic logic [1:0] shift_mode(op_e op);
    return (op == OP_SHL) ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/sterownik_rejestru_if.sv
// Host-side command/status bus of the shift-register sequencer.
interface sterownik_rejestru_if #(
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [3:0]       cmd_data;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [3:0]       result;

  // Host issues commands and observes status
  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data, abort,
    input  cmd_ready, busy, done, aborted, result
  );

  // Sequencer accepts commands and reports status
  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data, abort,
    output cmd_ready, busy, done, aborted, result
  );
endinterface

// File: rtl/rejestr_przesuwajacy.sv
// 4-bit bidirectional shift register: 00 hold, 01 right, 10 left, 11 load.
// Zero fill on both shift directions, synchronous active-high clear.
module rejestr_przesuwajacy
  import sterownik_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       s1,
  input  logic       s0,
  input  logic [3:0] i,
  output logic [3:0] q
);

  // Mode-selected next value, clear wins
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else begin
      case ({s1, s0})
        MODE_SHR:  q <= {1'b0, q[3:1]};
        MODE_SHL:  q <= {q[2:0], 1'b0};
        MODE_LOAD: q <= i;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sterownik_rejestru.sv
// Command sequencer for the 4-bit shift register: takes one host command,
// drives S1/S0/I/SR_CLR cycle by cycle, captures Q and pulses DONE.
module sterownik_rejestru
  import sterownik_pkg::*;
#(
  parameter int CNT_W = 3
)(
  input  logic                 clk,
  input  logic                 rst_n,
  sterownik_rejestru_if.slave  host,
  output logic                 s1,
  output logic                 s0,
  output logic [3:0]           i,
  output logic                 sr_clr,
  input  logic [3:0]           q_in
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_SHIFT = ST_SHIFT;
  localparam logic [2:0] S_CLEAR = ST_CLEAR;
  localparam logic [2:0] S_FIN   = ST_FIN;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  op_e              op_q;
  logic [3:0]       data_q;
  logic             abort_flag;
  logic             accept;
  logic             active;
  logic             abort_now;
  logic [1:0]       mode;
  logic             done_q;
  logic             aborted_q;
  logic [3:0]       result_q;

  assign host.cmd_ready = rst_n && (state == S_IDLE);
  assign accept         = host.cmd_valid && host.cmd_ready;
  assign active         = (state == S_LOAD) || (state == S_SHIFT) || (state == S_CLEAR);
  // ABORT only matters while the register is being worked on
  assign abort_now      = active && host.abort;
  assign host.busy      = (state != S_IDLE);
  assign host.done      = done_q;
  assign host.aborted   = aborted_q;
  assign host.result    = result_q;

  // Command latch and state sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= OP_LOAD;
      data_q     <= '0;
      abort_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          abort_flag <= 1'b0;
          if (accept) begin
            op_q   <= op_e'(host.cmd_op);
            data_q <= host.cmd_data;
            cnt    <= host.cmd_cnt;
            case (op_e'(host.cmd_op))
              OP_LOAD: state <= S_LOAD;
              OP_CLR:  state <= S_CLEAR;
              // zero-count shift completes without touching the register
              default: state <= (host.cmd_cnt == '0) ? S_FIN : S_SHIFT;
            endcase
          end
        end
        S_LOAD, S_CLEAR: begin
          if (abort_now) abort_flag <= 1'b1;
          state <= S_FIN;
        end
        S_SHIFT: begin
          // abort beats the last-shift exit; shifts done so far are kept
          if (abort_now) begin
            abort_flag <= 1'b1;
            state      <= S_FIN;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completion status: DONE lands in the first IDLE cycle with RESULT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= (state == S_FIN);
      if (state == S_FIN) begin
        result_q  <= q_in;
        aborted_q <= abort_flag;
      end
    end
  end

  // Register drive decoded from state; reset holds the register in clear
  always_comb begin
    mode   = MODE_HOLD;
    i      = '0;
    sr_clr = ~rst_n;
    if (rst_n && !abort_now) begin
      case (state)
        S_LOAD: begin
          mode = MODE_LOAD;
          i    = data_q;
        end
        S_SHIFT: mode   = shift_mode(op_q);
        S_CLEAR: sr_clr = 1'b1;
        default: ;
      endcase
    end
  end

  assign {s1, s0} = mode;

endmodule

// File: tb/tb_sterownik_rejestru.sv
// Bench for sterownik_rejestru driving a real rejestr_przesuwajacy.
// Expected per-cycle behaviour is derived from each command's latency and
// arithmetic result; literal values pin the main scenarios.
module tb_sterownik_rejestru;
  import sterownik_pkg::*;

  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sterownik_rejestru_if #(.CNT_W(CNT_W)) host_if();
  logic       s1, s0, sr_clr;
  logic [3:0] i_bus, q;

  sterownik_rejestru #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .host(host_if),
    .s1(s1), .s0(s0), .i(i_bus), .sr_clr(sr_clr), .q_in(q)
  );

  rejestr_przesuwajacy sr (
    .clk(clk), .rst(sr_clr), .s1(s1), .s0(s0), .i(i_bus), .q(q)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;
  logic [3:0] mq;

  // expectations keyed by cycle index (value of cyc at that negedge)
  bit         exp_busy[int];
  bit         exp_done[int];
  logic [3:0] exp_res[int];
  bit         exp_abt[int];
  logic [1:0] exp_mode[int];
  logic [3:0] exp_i[int];
  bit         exp_clr[int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int cc;
  // per-cycle compare against the expectation tables
  always @(negedge clk) begin
    if (check_en) begin
      cc = cyc;
      chk("done", {31'd0, host_if.done}, exp_done.exists(cc) ? 1 : 0);
      if (exp_done.exists(cc)) begin
        chk("result", {28'd0, host_if.result}, {28'd0, exp_res[cc]});
        chk("aborted", {31'd0, host_if.aborted}, {31'd0, exp_abt[cc]});
      end
      chk("busy", {31'd0, host_if.busy}, exp_busy.exists(cc) ? 1 : 0);
      chk("cmd_ready", {31'd0, host_if.cmd_ready}, (rst_n && !exp_busy.exists(cc)) ? 1 : 0);
      if (exp_mode.exists(cc)) chk("mode", {30'd0, s1, s0}, {30'd0, exp_mode[cc]});
      else                     chk("mode", {30'd0, s1, s0}, 0);
      if (exp_i.exists(cc)) chk("i", {28'd0, i_bus}, {28'd0, exp_i[cc]});
      chk("sr_clr", {31'd0, sr_clr}, (exp_clr.exists(cc) || !rst_n) ? 1 : 0);
    end
  end

  // Issue one command; returns accept edge index a and DONE cycle dc
  task automatic send(input logic [1:0] op, input int cnt, input logic [3:0] data,
                      input int abort_at, input bit keep, output int a, output int dc);
    int guard, k, len;
    bit abt;
    logic [3:0] res;
    @(posedge clk); #1;
    host_if.cmd_op    = op;
    host_if.cmd_cnt   = cnt[CNT_W-1:0];
    host_if.cmd_data  = data;
    host_if.cmd_valid = 1'b1;
    guard = 0;
    while (!host_if.cmd_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!host_if.cmd_ready) begin
      chk("accept_timeout", 0, 1);
      host_if.cmd_valid = 1'b0;
      a  = -1000;
      dc = -1000;
      return;
    end
    a = cyc + 1;
    abt = 1'b0;
    k   = 0;
    len = 3;
    if (op == OP_LOAD || op == OP_CLR) begin
      abt = (abort_at == 1);
    end else if (cnt == 0) begin
      len = 2;
    end else if (abort_at >= 1 && abort_at <= cnt) begin
      abt = 1'b1;
      k   = abort_at - 1;
      len = k + 3;
    end else begin
      k   = cnt;
      len = cnt + 2;
    end
    case (op)
      OP_LOAD: res = abt ? mq : data;
      OP_CLR:  res = abt ? mq : 4'b0000;
      OP_SHR:  res = mq >> k;
      default: res = mq << k;
    endcase
    for (int j = 0; j < len - 1; j++) exp_busy[a + j] = 1'b1;
    exp_done[a + len - 1] = 1'b1;
    exp_res[a + len - 1]  = res;
    exp_abt[a + len - 1]  = abt;
    if (!abt && op == OP_LOAD) begin
      exp_mode[a] = 2'b11;
      exp_i[a]    = data;
    end
    if (!abt && op == OP_CLR) exp_clr[a] = 1'b1;
    if (op == OP_SHR || op == OP_SHL)
      for (int j = 0; j < k; j++) exp_mode[a + j] = (op == OP_SHL) ? 2'b10 : 2'b01;
    mq = res;
    dc = a + len - 1;
    @(posedge clk); #1;
    if (!keep) host_if.cmd_valid = 1'b0;
    if (abort_at > 0) begin
      for (int j = 1; j <= abort_at; j++) begin
        if (j > 1) begin
          @(posedge clk); #1;
        end
        host_if.abort = (j == abort_at);
      end
      @(posedge clk); #1;
      host_if.abort = 1'b0;
    end
  endtask

  // Advance to the negedge of cycle dc and confirm DONE is up there
  task automatic wait_done(input string name, input int dc);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < dc && guard < 300);
    chk({name, "_done_cycle"}, cyc, dc);
    chk({name, "_done"}, {31'd0, host_if.done}, 1);
  endtask

  task automatic purge(input int from);
    for (int c = from; c < from + 64; c++) begin
      exp_busy.delete(c);
      exp_done.delete(c);
      exp_res.delete(c);
      exp_abt.delete(c);
      exp_mode.delete(c);
      exp_i.delete(c);
      exp_clr.delete(c);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, dc, a2, dc2;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 2'b00;
    host_if.cmd_cnt   = '0;
    host_if.cmd_data  = 4'b0000;
    host_if.abort     = 1'b0;
    mq = 4'b0000;
    #2 rst_n = 1'b0;

    // reset: 3 cycles low, then release
    @(posedge clk);
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'd0, host_if.cmd_ready}, 1);
    chk("reset_result", {28'd0, host_if.result}, 0);
    chk("reset_done", {31'd0, host_if.done}, 0);
    chk("reset_q", {28'd0, q}, 0);

    // load 1011
    send(OP_LOAD, 0, 4'b1011, 0, 0, a, dc);
    chk("load_latency", dc, a + 2);
    wait_done("load", a + 2);
    chk("load_result", {28'd0, host_if.result}, 32'hB);
    chk("load_aborted", {31'd0, host_if.aborted}, 0);

    // shift right 2: 1011 -> 0010
    send(OP_SHR, 2, 4'b0000, 0, 0, a, dc);
    wait_done("shr2", a + 3);
    chk("shr2_result", {28'd0, host_if.result}, 32'h2);

    // load 0111, shift left 5 -> 0000
    send(OP_LOAD, 0, 4'b0111, 0, 0, a, dc);
    wait_done("load7", a + 2);
    send(OP_SHL, 5, 4'b0000, 0, 0, a, dc);
    wait_done("shl5", a + 6);
    chk("shl5_result", {28'd0, host_if.result}, 32'h0);

    // shift right 0: no register activity
    send(OP_SHR, 0, 4'b0000, 0, 0, a, dc);
    wait_done("shr0", a + 1);
    chk("shr0_result", {28'd0, host_if.result}, 32'h0);

    // load 1111, shift left 3 aborted in its 2nd shift cycle -> 1110
    send(OP_LOAD, 0, 4'b1111, 0, 0, a, dc);
    wait_done("loadF", a + 2);
    send(OP_SHL, 3, 4'b0000, 2, 0, a, dc);
    wait_done("abort", a + 3);
    chk("abort_result", {28'd0, host_if.result}, 32'hE);
    chk("abort_flag", {31'd0, host_if.aborted}, 1);

    // back-to-back: clear then load 0101 with VALID held
    send(OP_CLR, 0, 4'b0000, 0, 1, a, dc);
    send(OP_LOAD, 0, 4'b0101, 0, 0, a2, dc2);
    chk("b2b_accept", a2, a + 3);
    wait_done("b2b", a + 5);
    chk("b2b_result", {28'd0, host_if.result}, 32'h5);
    chk("b2b_aborted", {31'd0, host_if.aborted}, 0);

    // reset in the middle of a shift
    send(OP_SHR, 5, 4'b0000, 0, 0, a, dc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    purge(cyc);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_q", {28'd0, q}, 0);
    chk("midrst_busy", {31'd0, host_if.busy}, 0);
    chk("midrst_done", {31'd0, host_if.done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq = 4'b0000;
    repeat (8) @(negedge clk);
    chk("midrst_idle_ready", {31'd0, host_if.cmd_ready}, 1);
    chk("midrst_result", {28'd0, host_if.result}, 0);

    // sequencer usable after reset
    send(OP_LOAD, 0, 4'b1001, 0, 0, a, dc);
    wait_done("post_rst", a + 2);
    chk("post_rst_result", {28'd0, host_if.result}, 32'h9);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
